// File: rtl/tm_delayline_if.sv
// tm_delayline_if: sample input and tap output handshakes of the shared-MAC delay line.
interface tm_delayline_if #(
  parameter int WL  = 14,
  parameter int LML = 4,
  parameter int LCH = 1
);
  logic           in_valid;
  logic           in_ready;
  logic [LCH-1:0] in_ch;
  logic [WL-1:0]  in_data;
  logic           tap_valid;
  logic           tap_ready;
  logic [WL-1:0]  tap_data;
  logic [LML-1:0] tap_idx;
  logic [LCH-1:0] tap_ch;
  logic           tap_last;
  logic           err;
  modport master (
    output in_valid, in_ch, in_data, tap_ready,
    input  in_ready, tap_valid, tap_data, tap_idx, tap_ch, tap_last, err
  );
  modport slave (
    input  in_valid, in_ch, in_data, tap_ready,
    output in_ready, tap_valid, tap_data, tap_idx, tap_ch, tap_last, err
  );
endinterface

// File: rtl/tm_delayline.sv
// tm_delayline: per-channel depth-M sample history, streamed newest-first to one shared MAC.
module tm_delayline #(
  parameter int M  = 16,
  parameter int WL = 14,
  parameter int CH = 1
) (
  input logic           clk,
  input logic           rst_n,
  input logic           i_en,
  input logic           i_clr,
  tm_delayline_if.slave s
);
  localparam int LML = $clog2(M);
  localparam int LCH = CH > 1 ? $clog2(CH) : 1;
  typedef enum logic {IDLE, STREAM} state_t;
  state_t         r_state;
  logic [WL-1:0]  r_mem [CH][M];
  logic [LML-1:0] r_wptr [CH];
  logic [LML:0]   r_fill [CH];
  logic           r_tap_valid;
  logic           r_tap_last;
  logic           r_err;
  logic [WL-1:0]  r_tap_data;
  logic [LML-1:0] r_tap_idx;
  logic [LCH-1:0] r_tap_ch;
  logic           w_hs;
  logic           w_rdy;
  logic           w_ok;
  logic           w_acc;
  logic           w_wr;
  logic [LCH-1:0] w_ci;
  logic [LML-1:0] w_wp;
  logic [LML-1:0] w_k1;
  logic [LML:0]   w_sum;
  logic [LML-1:0] w_addr;
  logic [WL-1:0]  w_rd;
  // Next tap read: x[n-k] lives at (wptr-1-k) mod M, zero beyond the filled history
  always_comb begin
    w_hs   = r_tap_valid & s.tap_ready;
    w_rdy  = i_en & ~i_clr & (r_state == IDLE | (w_hs & r_tap_last));
    w_ok   = int'(s.in_ch) < CH;
    w_acc  = s.in_valid & w_rdy;
    w_wr   = w_acc & w_ok;
    w_ci   = w_ok ? s.in_ch : '0;
    w_wp   = r_wptr[w_ci];
    w_k1   = r_tap_idx + LML'(1);
    w_sum  = {1'b0, r_wptr[r_tap_ch]} + (LML+1)'(M - 1) - {1'b0, w_k1};
    w_addr = LML'(w_sum >= (LML+1)'(M) ? w_sum - (LML+1)'(M) : w_sum);
    w_rd   = {1'b0, w_k1} < r_fill[r_tap_ch] ? r_mem[r_tap_ch][w_addr] : '0;
  end
  always_ff @(posedge clk)
    if (w_wr) r_mem[w_ci][w_wp] <= s.in_data;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      r_state     <= IDLE;
      r_tap_valid <= 1'b0;
      r_tap_data  <= '0;
      r_tap_idx   <= '0;
      r_tap_ch    <= '0;
      r_tap_last  <= 1'b0;
      r_err       <= 1'b0;
      for (int c = 0; c < CH; c++) begin
        r_wptr[c] <= '0;
        r_fill[c] <= '0;
      end
    end else if (i_en) begin
      r_err <= w_acc & ~w_ok;
      if (i_clr) begin
        r_state     <= IDLE;
        r_tap_valid <= 1'b0;
        for (int c = 0; c < CH; c++) begin
          r_wptr[c] <= '0;
          r_fill[c] <= '0;
        end
      end else if (w_wr) begin
        r_wptr[w_ci] <= w_wp == LML'(M - 1) ? '0 : w_wp + LML'(1);
        r_fill[w_ci] <= r_fill[w_ci] == (LML+1)'(M) ? r_fill[w_ci] : r_fill[w_ci] + (LML+1)'(1);
        r_state      <= STREAM;
        r_tap_valid  <= 1'b1;
        r_tap_data   <= s.in_data;
        r_tap_idx    <= '0;
        r_tap_ch     <= w_ci;
        r_tap_last   <= 1'b0;
      end else if (w_hs) begin
        if (r_tap_last) begin
          r_state     <= IDLE;
          r_tap_valid <= 1'b0;
        end else begin
          r_tap_data <= w_rd;
          r_tap_idx  <= w_k1;
          r_tap_last <= w_k1 == LML'(M - 1);
        end
      end
    end
  assign s.in_ready  = w_rdy;
  assign s.tap_valid = r_tap_valid;
  assign s.tap_data  = r_tap_data;
  assign s.tap_idx   = r_tap_idx;
  assign s.tap_ch    = r_tap_ch;
  assign s.tap_last  = r_tap_last;
  assign s.err       = r_err;
endmodule

// File: tb/tb_tm_delayline.sv
// tb_tm_delayline: table vectors, directed corner sequences and random traffic against a history-queue model.
module tb_tm_delayline;
  localparam int M = 4, WL = 14, CH = 3, LML = 2, LCH = 2;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic clr = 1'b0;
  int checks = 0;
  int failures = 0;
  int ncyc = 0;
  tm_delayline_if #(.WL(WL), .LML(LML), .LCH(LCH)) bus();
  tm_delayline #(.M(M), .WL(WL), .CH(CH)) dut (
    .clk(clk), .rst_n(rst_n), .i_en(en), .i_clr(clr), .s(bus)
  );
  always #5 clk = ~clk;
  typedef struct packed {
    logic [WL-1:0]  d;
    logic [LML-1:0] idx;
    logic [LCH-1:0] ch;
    logic           last;
  } tap_t;
  typedef struct {
    logic vi; logic [LCH-1:0] ch; logic [WL-1:0] d;
    logic rdy; logic tv; logic [WL-1:0] td; logic [LML-1:0] idx; logic last; logic err;
  } vec_t;
  tap_t pend[$];
  int   hist[CH][$];
  logic exp_err;
  logic [2:0] st;
  tap_t pl;
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, ncyc);
    end
  endtask
  task automatic model_reset();
    pend.delete();
    for (int c = 0; c < CH; c++) hist[c].delete();
    exp_err = 1'b0;
  endtask
  // One clock: drive, compare against the queue model at negedge, advance the model, step past posedge.
  task automatic cyc(input logic vi, input logic [LCH-1:0] ch, input logic [WL-1:0] d,
                     input logic tr, input logic e, input logic c);
    logic rdy;
    tap_t t;
    bus.in_valid = vi; bus.in_ch = ch; bus.in_data = d; bus.tap_ready = tr; en = e; clr = c;
    @(negedge clk);
    st = {bus.in_ready, bus.tap_valid, bus.err};
    pl = {bus.tap_data, bus.tap_idx, bus.tap_ch, bus.tap_last};
    rdy = e && !c && (pend.size() == 0 || (tr && pend.size() == 1));
    chk("ctl{rdy,valid,err}", 32'(st), 32'({rdy, pend.size() != 0, exp_err}));
    if (pend.size() != 0) chk("tap{data,idx,ch,last}", 32'(pl), 32'(pend[0]));
    if (e) begin
      if (c) model_reset();
      else begin
        if (pend.size() != 0 && tr) void'(pend.pop_front());
        exp_err = vi && rdy && int'(ch) >= CH;
        if (vi && rdy && int'(ch) < CH) begin
          hist[ch].push_front(int'(d));
          if (hist[ch].size() > M) void'(hist[ch].pop_back());
          for (int k = 0; k < M; k++) begin
            t.d    = k < hist[ch].size() ? WL'(hist[ch][k]) : '0;
            t.idx  = LML'(k);
            t.ch   = ch;
            t.last = k == M - 1;
            pend.push_back(t);
          end
        end
      end
    end
    ncyc++;
    @(posedge clk);
    #1;
  endtask
  task automatic send(input logic [LCH-1:0] ch, input logic [WL-1:0] d);
    for (int i = 0; i <= M + 1; i++) begin
      cyc(1'b1, ch, d, 1'b1, 1'b1, 1'b0);
      if (st[2]) return;
    end
    chk("send_timeout", 32'(0), 32'(1));
  endtask
  task automatic drain();
    for (int i = 0; i <= M + 2; i++) begin
      cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
      if (!st[1]) return;
    end
    chk("drain_timeout", 32'(0), 32'(1));
  endtask
  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end
  initial begin
    vec_t vt[16];
    logic [21:0] got, exp;
    int t0;
    bus.in_valid = 1'b0; bus.in_ch = '0; bus.in_data = '0; bus.tap_ready = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    chk("reset", 32'({bus.tap_valid, bus.tap_data, bus.tap_idx, bus.tap_ch, bus.tap_last, bus.err}), 32'(0));
    rst_n = 1'b1;
    // {in_valid, in_ch, in, exp in_ready, tap_valid, tap_data, tap_idx, tap_last, err}
    vt = '{
      '{1, 0,  1, 1, 0, 0, 0, 0, 0},
      '{0, 0,  0, 0, 1, 1, 0, 0, 0},
      '{0, 0,  0, 0, 1, 0, 1, 0, 0},
      '{0, 0,  0, 0, 1, 0, 2, 0, 0},
      '{1, 0,  2, 1, 1, 0, 3, 1, 0},
      '{0, 0,  0, 0, 1, 2, 0, 0, 0},
      '{0, 0,  0, 0, 1, 1, 1, 0, 0},
      '{0, 0,  0, 0, 1, 0, 2, 0, 0},
      '{1, 0,  3, 1, 1, 0, 3, 1, 0},
      '{0, 0,  0, 0, 1, 3, 0, 0, 0},
      '{0, 0,  0, 0, 1, 2, 1, 0, 0},
      '{0, 0,  0, 0, 1, 1, 2, 0, 0},
      '{0, 0,  0, 1, 1, 0, 3, 1, 0},
      '{1, 3, 55, 1, 0, 0, 0, 0, 0},
      '{0, 0,  0, 1, 0, 0, 0, 0, 1},
      '{0, 0,  0, 1, 0, 0, 0, 0, 0}
    };
    foreach (vt[i]) begin
      cyc(vt[i].vi, vt[i].ch, vt[i].d, 1'b1, 1'b1, 1'b0);
      got = {st, vt[i].tv ? pl : tap_t'(0)};
      exp = {vt[i].rdy, vt[i].tv, vt[i].err, vt[i].tv ? {vt[i].td, vt[i].idx, LCH'(0), vt[i].last} : 19'(0)};
      chk($sformatf("vec%0d", i), 32'(got), 32'(exp));
    end
    // Saturation and wrap: 1..6 leaves history 6,5,4,3
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      send(0, WL'(i));
      drain();
    end
    // Interleaved channels
    send(0, 10);  drain();
    send(1, 100); drain();
    send(0, 20);  drain();
    send(1, 200); drain();
    // Backpressure at k=1, then enable freeze
    send(2, 7);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    repeat (3) begin
      cyc(1'b1, 0, 5, 1'b0, 1'b1, 1'b0);
      chk("bp_hold_idx", 32'(bus.tap_idx), 32'(1));
    end
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    chk("bp_release_idx", 32'(bus.tap_idx), 32'(2));
    repeat (2) cyc(1'b1, 0, 5, 1'b1, 1'b0, 1'b0);
    drain();
    // Back-to-back: five samples finish in 5*M+1 cycles
    t0 = ncyc;
    for (int i = 0; i < 5; i++) send(0, WL'(40 + i));
    drain();
    chk("b2b_cycles", 32'(ncyc - t0 - 1), 32'(5 * M + 1));
    // Clear at k=2, then a fresh sample streams against empty history
    send(0, 7);
    repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b1);
    send(0, 9); drain();
    // Same with an asynchronous reset pulse mid-stream
    send(0, 7);
    repeat (2) cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    rst_n = 1'b0;
    #1;
    chk("async_rst_valid", 32'(bus.tap_valid), 32'(0));
    model_reset();
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    send(0, 9); drain();
    // Out-of-range channel leaves history intact
    send(1, 300); drain();
    cyc(1'b1, 3, 77, 1'b1, 1'b1, 1'b0);
    cyc(1'b0, '0, '0, 1'b1, 1'b1, 1'b0);
    send(1, 301); drain();
    // Random traffic
    for (int i = 0; i < 1500; i++)
      cyc(1'($urandom_range(0, 1)), LCH'($urandom_range(0, 3)), WL'($urandom),
          $urandom_range(0, 9) < 7, $urandom_range(0, 9) != 0, $urandom_range(0, 59) == 0);
    drain();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/tm_delayline.md
Name: tm_delayline

Overview:
- Parametrised successor to the single-SRL delay line for the time-multiplexed FIR datapath.
- Holds a depth-M sample history for each of CH interleaved channels.
- After each accepted sample, streams all M taps, newest first, one per handshake, to a single shared MAC.
- Unwritten history reads as zero after reset or clear, so no memory sweep is needed.

Parameters:
- M, 16, taps per channel (M >= 2).
- WL, 14, sample word length.
- CH, 1, number of interleaved channels (CH >= 1).
- LML, $clog2(M), tap index width (derived, not overridden).
- LCH, max(1,$clog2(CH)), channel index width (derived).

Ports:
- CLK  in  1  clock, rising edge.
- RSTN  in  1  asynchronous active-low reset.
- EN  in  1  global clock enable; low freezes all state and outputs.
- clr  in  1  synchronous clear of history and FSM (qualified by EN).
- in_valid  in  1  input sample valid.
- in_ready  out  1  block can accept a sample this cycle.
- in_ch  in  LCH  channel of input sample.
- in  in  WL  input sample.
- tap_valid  out  1  tap output valid.
- tap_ready  in  1  MAC accepts tap.
- tap_data  out  WL  tap value x[n-k].
- tap_idx  out  LML  k, 0..M-1.
- tap_ch  out  LCH  channel being streamed.
- tap_last  out  1  high with k == M-1.
- err  out  1  one-cycle pulse: sample accepted with in_ch >= CH, discarded.

Behaviour:
- Reset (RSTN=0, async): FSM=IDLE; all wptr[c]=0; all fill[c]=0; tap_valid=0, tap_data=0, tap_idx=0, tap_ch=0, tap_last=0, err=0. Memory contents are not reset.
- Storage: CH circular buffers of M words (distributed RAM/regs), per-channel write pointer wptr[c] (mod M) and fill count fill[c] (saturates at M).
- Accept = EN & in_valid & in_ready.
- in_ready = EN & !clr & (state==IDLE | (tap_valid & tap_ready & tap_last)).
- On accept with in_ch < CH:
  - mem[in_ch][wptr] <= in; wptr <= (wptr+1) mod M; fill <= min(fill+1, M).
  - Latch ch <= in_ch, k <= 0; state -> STREAM.
  - tap_valid=1 from the next cycle (1-cycle latency).
- On accept with in_ch >= CH: nothing written; err=1 the next cycle for one cycle; state stays or goes IDLE.
- STREAM:
  - tap_data = (k < fill[ch]) ? mem[ch][(wptr[ch]-1-k) mod M] : 0, registered together with tap_idx=k, tap_ch=ch, tap_last=(k==M-1).
  - Outputs hold stable while tap_valid & !tap_ready.
  - On EN & tap_ready: if k < M-1, k <= k+1 and the next tap is presented the next cycle. If k == M-1, go IDLE, or go STREAM(k=0) for the new sample if accepted in the same cycle.
- Sustained throughput: one sample per M cycles with tap_ready tied high.
- EN=0: no state change; in_ready=0; outputs hold; tap_ready is ignored.
- clr (with EN): priority over accept and handshake. Next cycle: FSM=IDLE, all fill=0, all wptr=0, tap_valid=0. Subsequent history reads zero.
- RSTN low mid-stream: tap_valid drops asynchronously. After release, the stream restarts only on a new accept.
- Wrap-around: wptr M-1 -> 0. Tap addressing is mod M, so after more than M samples the oldest sample is overwritten.
- Channels are independent: a sample on one channel never alters another channel's wptr, fill or data.

Test Plan:
- M=4, CH=1, tap_ready=1: send 1,2,3 -> streams 1,0,0,0 then 2,1,0,0 then 3,2,1,0. tap_idx 0..3, tap_last on idx 3.
- M=4: send 1..6 -> last stream 6,5,4,3. fill saturates at 4; wptr wraps to 2.
- CH=2, M=4: alternate ch0:10,20 and ch1:100,200, i.e. sequence 10(c0),100(c1),20(c0),200(c1) -> c0 stream 20,10,0,0 and c1 stream 200,100,0,0. tap_ch correct on each stream.
- Backpressure: tap_ready low for 3 cycles at k=1 -> tap_data/tap_idx held, in_ready=0. Release -> k=2 the next cycle. EN low for 2 cycles mid-stream -> full freeze.
- Back-to-back: in_valid held with tap_ready=1 -> new sample accepted on the tap_last cycle; next cycle k=0, no bubble; 5 samples finish in 5*M+1 cycles.
- clr at k=2 of the stream for 7, then send 9 -> tap_valid low the next cycle; stream is 9,0,0,0. Repeat with RSTN pulse -> same result. in_ch=CH -> err pulse, no stream, history unchanged.
